// File: rtl/feeder_pkg.sv
// ============================================================================
// Module  : feeder_pkg
// Brief   : Shared state encoding and coordinate-width helpers for pixel_feeder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

    function automatic int COL_W(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int ROW_W(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ============================================================================
// Module  : raster_counter
// Brief   : Column/row position of the next pixel to accept, with end-of-frame
//           and interior-neighbourhood flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module raster_counter
    import feeder_pkg::*;
#(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_clear,
    input  logic                      i_inc,
    output logic [COL_W(WIDTH)-1:0]   o_col,
    output logic [ROW_W(HEIGHT)-1:0]  o_row,
    output logic                      o_last,
    output logic                      o_interior
);

    localparam int c_col_w = COL_W(WIDTH);
    localparam int c_row_w = ROW_W(HEIGHT);

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic               w_col_end;
    logic               w_row_end;

    assign w_col_end = (r_col == c_col_w'(WIDTH - 1));
    assign w_row_end = (r_row == c_row_w'(HEIGHT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_inc) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_last     = w_col_end & w_row_end;
    // A full 3x3 neighbourhood needs two earlier rows and two earlier columns.
    assign o_interior = (r_row >= c_row_w'(2)) & (r_col >= c_col_w'(2));

endmodule

`default_nettype wire

// File: rtl/pixel_feeder.sv
// ============================================================================
// Module  : pixel_feeder
// Brief   : Raster pixel source for the 3x3 line buffer; flags interior windows
//           and stalls while a window is unconsumed. FEEDER_COORD_EN adds
//           win_row/win_col window-centre outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_feeder
    import feeder_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          shift_en,
    output logic [7:0]                    pixel_out,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic                          frame_done,
    output logic                          busy
`ifdef FEEDER_COORD_EN
    ,
    output logic [ROW_W(IMG_HEIGHT)-1:0]  win_row,
    output logic [COL_W(IMG_WIDTH)-1:0]   win_col
`endif
);

    localparam int c_col_w = COL_W(IMG_WIDTH);
    localparam int c_row_w = ROW_W(IMG_HEIGHT);

    feeder_state_t      r_state;
    feeder_state_t      w_state_nxt;
    logic               r_win_valid;
    logic               w_accept;
    logic               w_clear;
    logic               w_last;
    logic               w_interior;
    logic [c_col_w-1:0] w_col;
    logic [c_row_w-1:0] w_row;

    // A pending, unconsumed window blocks shifting so it is never overwritten.
    assign in_ready  = (r_state == ST_STREAM) & ~(r_win_valid & ~win_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_clear   = (r_state == ST_IDLE) & start;
    assign shift_en  = w_accept;
    assign pixel_out = in_data;

    raster_counter #(
        .WIDTH      (IMG_WIDTH),
        .HEIGHT     (IMG_HEIGHT)
    ) u_raster_counter (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_inc      (w_accept),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_last     (w_last),
        .o_interior (w_interior)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_accept && w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!r_win_valid || win_ready) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_win_valid <= 1'b0;
        end else if (w_accept) begin
            r_win_valid <= w_interior;
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

    assign win_valid  = r_win_valid;
    assign frame_done = (r_state == ST_DONE);
    assign busy       = (r_state == ST_STREAM) | (r_state == ST_DRAIN);

`ifdef FEEDER_COORD_EN
    logic [c_row_w-1:0] r_win_row;
    logic [c_col_w-1:0] r_win_col;

    // The completing pixel is the bottom-right corner; the centre is one up-left.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_win_row <= '0;
            r_win_col <= '0;
        end else if (w_accept && w_interior) begin
            r_win_row <= w_row - 1'b1;
            r_win_col <= w_col - 1'b1;
        end
    end

    assign win_row = r_win_row;
    assign win_col = r_win_col;
`else
    logic w_coord_unused;
    assign w_coord_unused = ^{w_row, w_col};
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_feeder.sv
// ============================================================================
// Module  : tb_pixel_feeder
// Brief   : Scoreboard bench for pixel_feeder on a 4x4 image with a model line buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pixel_feeder;
    import feeder_pkg::*;

    localparam int W        = 4;
    localparam int H        = 4;
    localparam int LB_DEPTH = 2 * W + 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       shift_en;
    logic [7:0] pixel_out;
    logic       win_valid;
    logic       win_ready;
    logic       frame_done;
    logic       busy;
`ifdef FEEDER_COORD_EN
    logic [ROW_W(H)-1:0] win_row;
    logic [COL_W(W)-1:0] win_col;
`endif

    pixel_feeder #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .pixel_out  (pixel_out),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef FEEDER_COORD_EN
        ,
        .win_row    (win_row),
        .win_col    (win_col)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int row;
        int col;
        int pix;
    } win_exp_t;

    int         n_vec = 0;
    int         n_err = 0;
    win_exp_t   sb[$];
    win_exp_t   e_pop;
    logic [7:0] lb [LB_DEPTH];
    int         pos_r = 0;
    int         pos_c = 0;
    int         cur_base = 0;
    logic       wv_exp = 1'b0;
    int         neg_cnt = 0;
    int         last_acc = 0;
    int         win_seen = 0;
    int         done_seen = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference monitor: model line buffer, position tracker and window scoreboard.
    always @(negedge clock) begin
        neg_cnt++;
        if (reset) begin
            wv_exp = 1'b0;
            pos_r  = 0;
            pos_c  = 0;
        end else begin
            check_val("win_valid", int'(win_valid), int'(wv_exp));
            if (win_valid && win_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 1, 0);
                end else begin
                    e_pop = sb.pop_front();
                    check_val("win_pix", int'(lb[W+1]), e_pop.pix);
`ifdef FEEDER_COORD_EN
                    check_val("win_row", int'(win_row), e_pop.row);
                    check_val("win_col", int'(win_col), e_pop.col);
`endif
                end
                win_seen++;
            end
            if (frame_done) begin
                done_seen++;
                check_val("done_latency", neg_cnt - last_acc, 2);
            end
            if (start && !busy && !frame_done) begin
                pos_r = 0;
                pos_c = 0;
            end
            if (shift_en) begin
                check_val("pixel_order", int'(pixel_out), (cur_base + pos_r * W + pos_c) % 256);
                last_acc = neg_cnt;
                wv_exp   = (pos_r >= 2) && (pos_c >= 2);
                for (int k = LB_DEPTH - 1; k > 0; k--) lb[k] = lb[k-1];
                lb[0] = pixel_out;
                if (pos_c == W - 1) begin
                    pos_c = 0;
                    pos_r = (pos_r == H - 1) ? 0 : pos_r + 1;
                end else begin
                    pos_c++;
                end
            end else if (win_ready) begin
                wv_exp = 1'b0;
            end
        end
    end

    task automatic push_exp(input int base, input int idx);
        win_exp_t e;
        int r, c;
        r = idx / W;
        c = idx % W;
        if (r >= 2 && c >= 2) begin
            e.row = r - 1;
            e.col = c - 1;
            e.pix = (base + (r - 1) * W + (c - 1)) % 256;
            sb.push_back(e);
        end
    endtask

    task automatic send_pixel(input int v, output int waited);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = 8'(v);
        @(negedge clock);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) check_val("accept_timeout", 0, 1);
        waited = n;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // mode 0: plain, 1: backpressure after pixel 10, 2: bubbles + start mid-frame, 3: reset after pixel 7
    task automatic run_frame(input int base, input int mode);
        int wins0, done0, n, waited;
        wins0    = win_seen;
        done0    = done_seen;
        cur_base = base;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < W * H; i++) begin
            push_exp(base, i);
            if (mode == 2) begin
                @(posedge clock); #1;
            end
            if (mode == 2 && i == 5) start = 1'b1;
            send_pixel(base + i, waited);
            start = 1'b0;
            if (mode == 1 && i == 11) check_val("bp_release_wait", waited, 0);
            if (mode == 1 && i == 10) begin
                win_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 8'(base + 11);
                repeat (5) begin
                    @(negedge clock);
                    check_val("bp_in_ready", int'(in_ready), 0);
                    check_val("bp_shift_en", int'(shift_en), 0);
                    check_val("bp_win_held", int'(win_valid), 1);
                end
                @(posedge clock); #1;
                win_ready = 1'b1;
            end
            if (mode == 3 && i == 7) begin
                reset    = 1'b1;
                in_valid = 1'b1;
                start    = 1'b1;
                @(negedge clock);
                check_val("rst_in_ready", int'(in_ready), 0);
                check_val("rst_shift_en", int'(shift_en), 0);
                check_val("rst_win_valid", int'(win_valid), 0);
                check_val("rst_busy", int'(busy), 0);
                check_val("rst_frame_done", int'(frame_done), 0);
                @(posedge clock); #1;
                reset    = 1'b0;
                in_valid = 1'b0;
                start    = 1'b0;
                sb.delete();
                repeat (6) @(negedge clock);
                #1;
                check_val("rst_no_done", done_seen - done0, 0);
                check_val("rst_idle_busy", int'(busy), 0);
                @(posedge clock); #1;
                return;
            end
        end
        n = 0;
        while (done_seen == done0 && n < 20) begin
            @(negedge clock); #1;
            n++;
        end
        check_val("frame_done_count", done_seen - done0, 1);
        check_val("windows_per_frame", win_seen - wins0, (W - 2) * (H - 2));
        check_val("sb_empty", sb.size(), 0);
        @(negedge clock);
        check_val("done_pulse_width", int'(frame_done), 0);
        check_val("idle_busy", int'(busy), 0);
        @(posedge clock); #1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        win_ready = 1'b1;
        @(negedge clock);
        check_val("reset_in_ready", int'(in_ready), 0);
        check_val("reset_win_valid", int'(win_valid), 0);
        check_val("reset_frame_done", int'(frame_done), 0);
        check_val("reset_busy", int'(busy), 0);
`ifdef FEEDER_COORD_EN
        check_val("reset_win_row", int'(win_row), 0);
        check_val("reset_win_col", int'(win_col), 0);
`endif
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // in_valid while idle must not shift anything
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) begin
            @(negedge clock);
            check_val("idle_shift_en", int'(shift_en), 0);
            check_val("idle_in_ready", int'(in_ready), 0);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;

        run_frame(0,  0);
        run_frame(16, 1);
        run_frame(32, 2);
        run_frame(48, 3);
        run_frame(64, 0);
        run_frame(80, 0);
        run_frame(96, 0);

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/pixel_feeder.md
# pixel_feeder

Raster-order pixel source controller for the edge-detection line buffer. It accepts a frame's pixels over a valid/ready stream and drives the line buffer's `shift_en`/`pixel_in` port. It tracks row/column position and flags each cycle in which the buffer holds a complete interior 3x3 neighbourhood. It also applies backpressure from the downstream gradient stage so that a held window is never overwritten.

## Interface
- `IMG_WIDTH`, 720, pixels per line; must match the line buffer; minimum 3.
- `IMG_HEIGHT`, 540, lines per frame; minimum 3.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `in_valid`  in  1  upstream pixel present.
- `in_data`  in  8  upstream pixel, raster order.
- `in_ready`  out  1  feeder accepts `in_data` this cycle.
- `shift_en`  out  1  line-buffer shift strobe; combinational, equals `in_valid & in_ready`.
- `pixel_out`  out  8  line-buffer input; combinational pass-through of `in_data`.
- `win_valid`  out  1  line-buffer window is an interior neighbourhood.
- `win_ready`  in  1  downstream consumed the window.
- `frame_done`  out  1  one-cycle pulse after the last window of the frame is consumed.
- `busy`  out  1  high in STREAM and DRAIN.
- `win_row`  out  ROW_W  center row of the current window; present only with `FEEDER_COORD_EN`.
- `win_col`  out  COL_W  center column of the current window; present only with `FEEDER_COORD_EN`.

## Operation
- **FSM states:** IDLE, STREAM, DRAIN, DONE.
  - IDLE -> STREAM on `start`.
  - STREAM -> DRAIN when the last pixel (row H-1, col W-1) is accepted.
  - DRAIN -> DONE when `win_valid` is low, or when `win_valid & win_ready`.
  - DONE -> IDLE unconditionally. `frame_done` = (state == DONE).
- **in_ready:** `in_ready = (state == STREAM) & ~(win_valid & ~win_ready)`.
  - A pending unconsumed window blocks shifting.
  - Accept and consume may occur in the same cycle.
- **Counters:** `col` 0..W-1, `row` 0..H-1 hold the position of the next pixel to accept.
  - On accept: `col` increments; wrapping from W-1 to 0 increments `row`.
  - Both counters clear on entry to STREAM.
- **Window validity:** an accepted pixel at (r, c) with r >= 2 and c >= 2 sets `win_valid` at the same edge. The center is (r-1, c-1).
  - If the accepted pixel is not interior, `win_valid` clears at that edge when it was consumed or low.
  - With no accept: a consume clears `win_valid`; otherwise `win_valid` holds.
- **Window count:** (W-2)*(H-2) windows per frame. No border windows are produced.
- **Line buffer contents:** not cleared between frames. Stale data never reaches a valid window, because the buffer depth is 2W+3.
- **Ignored inputs:** `start` outside IDLE is ignored. `in_valid` outside STREAM is ignored.

## Timing
- **Reset values:** state IDLE; `in_ready` 0, `win_valid` 0, `frame_done` 0, `busy` 0; `win_row` 0, `win_col` 0; counters 0.
- **Window latency:** `win_valid` rises at the same clock edge at which the line buffer shifts in the completing pixel. The window is therefore valid in the first cycle after acceptance.
- **Throughput:** 1 pixel/cycle when `win_ready` is held high.
- **Reset mid-frame:** the FSM returns to IDLE immediately and no `frame_done` is issued. The next frame requires `start`.
- **frame_done timing:** with `win_ready` high, `frame_done` rises 2 cycles after the last pixel is accepted (DRAIN, then DONE).

## Configuration
- `FEEDER_COORD_EN` defined: `win_row`/`win_col` ports exist as registers, updated together with `win_valid`.
  - ROW_W = $clog2(IMG_HEIGHT), COL_W = $clog2(IMG_WIDTH).
- Not defined: the ports and registers are absent. All other behaviour is identical.

## Structure
- **Package `feeder_pkg`:** state enum `feeder_state_t`, and the width helpers `COL_W(width)`/`ROW_W(height)` as functions.
- **Sub-module `raster_counter`:** col/row counter with clear, increment, `last` (H-1, W-1) and `interior` (r >= 2 && c >= 2) flags.
- The line buffer is instantiated beside the feeder at top level, not inside it.

## Test plan
All scenarios use W=4, H=4, `win_ready`=1 and pixel value = raster index, unless stated.

1. **Full frame:** 16 pixels in, `in_valid` held high.
   - `win_valid` is seen 4 times, after pixels 10, 11, 14, 15.
   - Centers are (1,1), (1,2), (2,1), (2,2).
   - `frame_done` pulses once, 2 cycles after pixel 15.
2. **Backpressure:** `win_ready`=0 for 5 cycles after pixel 10.
   - `in_ready`=0 and `shift_en`=0 throughout; the window is held.
   - On release, pixel 11 is accepted in the same cycle as the consume.
3. **Upstream bubbles:** `in_valid` toggles every cycle.
   - Same 4 windows; `shift_en` only on accepted cycles.
4. **Reset mid-frame:** assert `reset` after pixel 7.
   - All outputs return to reset values; no `frame_done`.
   - A following `start` plus 16 pixels yields 4 windows.
5. **Ignored inputs:** `start` during STREAM and `in_valid` in IDLE.
   - No effect on the counters or on `shift_en`.
6. **Back-to-back frames:** `FEEDER_COORD_EN` defined, two frames.
   - Second-frame windows have correct coordinates and pixels from that frame only.
